// File: rtl/fft_pkg.sv
`default_nettype none
// =====================================================================
// fft_pkg : twiddle-select encodings and W8 coefficient helper
// Rev 1.0
// =====================================================================
package fft_pkg;

   localparam logic [1:0] TW_ONE = 2'd0;   // W = 1
   localparam logic [1:0] TW_MJ  = 2'd1;   // W = -j
   localparam logic [1:0] TW_W81 = 2'd2;   // W = (1-j)/sqrt2
   localparam logic [1:0] TW_W83 = 2'd3;   // W = (-1-j)/sqrt2

   // round(2^cw/sqrt2) == round(sqrt(2^(2cw-1))), found by bitwise integer sqrt
   function automatic logic [31:0] k_coef(input int cw);
      logic [63:0] n;
      logic [63:0] t;
      logic [63:0] r64;
      logic [31:0] r;
      n = 64'd1 << (2 * cw - 1);
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = {32'd0, r} | (64'd1 << b);
         if (t * t <= n) r = t[31:0];
      end
      r64 = {32'd0, r};
      if (n - r64 * r64 > r64) r = r + 32'd1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_cmul_w8.sv
`default_nettype none
// =====================================================================
// fft_cmul_w8 : one-component multiply by 1/sqrt2 with round-half-up
// Rev 1.0
// =====================================================================
module fft_cmul_w8
   import fft_pkg::*;
#(
   parameter int DW = 16,
   parameter int CW = 15
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 mul,
   input  logic signed [DW+1:0] p,
   output logic signed [DW:0]   q
);

   localparam int                 c_pw   = DW + CW + 3;
   localparam logic [31:0]        c_k32  = k_coef(CW);
   localparam logic signed [c_pw-1:0] c_k    = {{(c_pw-CW-1){1'b0}}, c_k32[CW:0]};
   localparam logic signed [c_pw-1:0] c_half = {{(c_pw-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};

   logic signed [c_pw-1:0] w_pe;
   logic signed [c_pw-1:0] w_prod;
   logic signed [c_pw-1:0] w_rnd;
   logic signed [DW:0]     w_q;
   logic                   w_unused;

   assign w_pe   = {{(CW+1){p[DW+1]}}, p};
   assign w_prod = w_pe * c_k;
   assign w_rnd  = w_prod + c_half;
   // |p*K/2^CW| stays below 2^DW, so the DW+1 slice above the fraction is exact
   assign w_q    = mul ? w_rnd[DW+CW:CW] : p[DW:0];
   assign w_unused = ^{w_rnd[c_pw-1:DW+CW+1], w_rnd[CW-1:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else if (en)  q <= w_q;
   end

endmodule
`default_nettype wire

// File: rtl/fft_bf_stage_p.sv
`default_nettype none
// =====================================================================
// fft_bf_stage_p : 3-stage radix-2 DIT butterfly, W8 twiddles, sat/scale
// Rev 1.0
// =====================================================================
module fft_bf_stage_p
   import fft_pkg::*;
#(
   parameter int DW  = 16,
   parameter int CW  = 15,
   parameter int SAT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [1:0]           tw_sel,
   input  logic                 scale,
   input  logic signed [DW-1:0] a_re,
   input  logic signed [DW-1:0] a_im,
   input  logic signed [DW-1:0] b_re,
   input  logic signed [DW-1:0] b_im,
   input  logic                 ovf_clr,
   output logic                 out_valid,
   output logic signed [DW-1:0] x_re,
   output logic signed [DW-1:0] x_im,
   output logic signed [DW-1:0] y_re,
   output logic signed [DW-1:0] y_im,
   output logic                 ovf
);

   localparam logic signed [DW+1:0] c_one = {{(DW+1){1'b0}}, 1'b1};
   localparam logic signed [DW+1:0] c_max = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] c_min = {3'b111, {(DW-1){1'b0}}};

   // one extra pre-product bit so -b_re-b_im cannot wrap at the most negative B
   logic signed [DW+1:0] w_bre, w_bim, w_p_re, w_p_im;
   logic                 r1_valid, r1_mul, r1_scale;
   logic signed [DW-1:0] r1_a_re, r1_a_im;
   logic signed [DW+1:0] r1_p_re, r1_p_im;
   logic                 r2_valid, r2_scale;
   logic signed [DW-1:0] r2_a_re, r2_a_im;
   logic signed [DW:0]   r2_bw_re, r2_bw_im;
   logic signed [DW+1:0] w_ar, w_ai, w_br, w_bi;
   logic [DW:0]          w_px_re, w_px_im, w_py_re, w_py_im;
   logic                 w_clip;

   assign w_bre = {{2{b_re[DW-1]}}, b_re};
   assign w_bim = {{2{b_im[DW-1]}}, b_im};

   always_comb begin
      w_p_re = w_bre;
      w_p_im = w_bim;
      case (tw_sel)
         TW_ONE: begin w_p_re = w_bre;         w_p_im = w_bim;          end
         TW_MJ:  begin w_p_re = w_bim;         w_p_im = -w_bre;         end
         TW_W81: begin w_p_re = w_bre + w_bim; w_p_im = w_bim - w_bre;  end
         default:begin w_p_re = w_bim - w_bre; w_p_im = -w_bre - w_bim; end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r1_valid <= 1'b0;
         r1_mul   <= 1'b0;
         r1_scale <= 1'b0;
         r1_a_re  <= '0;
         r1_a_im  <= '0;
         r1_p_re  <= '0;
         r1_p_im  <= '0;
         r2_valid <= 1'b0;
         r2_scale <= 1'b0;
         r2_a_re  <= '0;
         r2_a_im  <= '0;
      end else begin
         r1_valid <= in_valid;
         r2_valid <= r1_valid;
         if (in_valid) begin
            r1_mul   <= (tw_sel == TW_W81) || (tw_sel == TW_W83);
            r1_scale <= scale;
            r1_a_re  <= a_re;
            r1_a_im  <= a_im;
            r1_p_re  <= w_p_re;
            r1_p_im  <= w_p_im;
         end
         if (r1_valid) begin
            r2_scale <= r1_scale;
            r2_a_re  <= r1_a_re;
            r2_a_im  <= r1_a_im;
         end
      end
   end

   fft_cmul_w8 #(.DW(DW), .CW(CW)) u_cmul_re (
      .clk(clk), .reset_n(reset_n), .en(r1_valid), .mul(r1_mul),
      .p(r1_p_re), .q(r2_bw_re)
   );

   fft_cmul_w8 #(.DW(DW), .CW(CW)) u_cmul_im (
      .clk(clk), .reset_n(reset_n), .en(r1_valid), .mul(r1_mul),
      .p(r1_p_im), .q(r2_bw_im)
   );

   // returns {clipped, DW-bit result} after optional halving and sat/wrap
   function automatic logic [DW:0] post(input logic signed [DW+1:0] v, input logic sc);
      logic signed [DW+1:0] s;
      logic                 clip;
      logic [DW-1:0]        r;
      s    = sc ? ((v + c_one) >>> 1) : v;
      clip = (s > c_max) || (s < c_min);
      r    = s[DW-1:0];
      if ((SAT != 0) && clip) r = s[DW+1] ? c_min[DW-1:0] : c_max[DW-1:0];
      return {clip, r};
   endfunction

   assign w_ar = {{2{r2_a_re[DW-1]}}, r2_a_re};
   assign w_ai = {{2{r2_a_im[DW-1]}}, r2_a_im};
   assign w_br = {r2_bw_re[DW], r2_bw_re};
   assign w_bi = {r2_bw_im[DW], r2_bw_im};

   assign w_px_re = post(w_ar + w_br, r2_scale);
   assign w_px_im = post(w_ai + w_bi, r2_scale);
   assign w_py_re = post(w_ar - w_br, r2_scale);
   assign w_py_im = post(w_ai - w_bi, r2_scale);
   assign w_clip  = w_px_re[DW] | w_px_im[DW] | w_py_re[DW] | w_py_im[DW];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         x_re      <= '0;
         x_im      <= '0;
         y_re      <= '0;
         y_im      <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= r2_valid;
         if (r2_valid) begin
            x_re <= w_px_re[DW-1:0];
            x_im <= w_px_im[DW-1:0];
            y_re <= w_py_re[DW-1:0];
            y_im <= w_py_im[DW-1:0];
         end
         if (r2_valid && w_clip) ovf <= 1'b1;
         else if (ovf_clr)       ovf <= 1'b0;
      end
   end

endmodule
`default_nettype wire
